// File: rtl/programmable_mealy_fsm.sv
// Table-driven Mealy engine: transition/output table loaded through a config port, run/step advance control.
// Optional state-change counter enabled by defining PROGRAMMABLE_MEALY_FSM_TRANS_CNT_EN.
module programmable_mealy_fsm #(
    parameter int STATE_W     = 2,
    parameter int IN_W        = 2,
    parameter int OUT_W       = 2,
    parameter int RESET_STATE = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       run,
    input  logic                       step,
    input  logic [IN_W-1:0]            in_x,
    output logic [OUT_W-1:0]           out_y,
    output logic [STATE_W-1:0]         cur_state,
    input  logic                       cfg_we,
    input  logic [STATE_W+IN_W-1:0]    cfg_addr,
    input  logic [STATE_W+OUT_W-1:0]   cfg_wdata,
    output logic                       cfg_err,
    output logic [15:0]                trans_cnt
);

    localparam int ADDR_W  = STATE_W + IN_W;
    localparam int ENTRY_W = STATE_W + OUT_W;
    localparam int DEPTH   = 1 << ADDR_W;

    logic [ENTRY_W-1:0] entries [DEPTH];
    logic               adv;
    logic [ADDR_W-1:0]  rd_addr;
    logic [ENTRY_W-1:0] rd_entry;
    logic [STATE_W-1:0] next_state;

    always_comb begin
        adv        = run | step;
        rd_addr    = {cur_state, in_x};
        rd_entry   = entries[rd_addr];
        out_y      = rd_entry[OUT_W-1:0];
        next_state = cur_state;
        if (adv) begin
            next_state = rd_entry[ENTRY_W-1 -: STATE_W];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_state <= STATE_W'(RESET_STATE);
        end else begin
            cur_state <= next_state;
        end
    end

    // Reset turns every entry into a zero-output self-loop; writes collide with an advance and are dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[ADDR_W'(i)] <= {STATE_W'(i >> IN_W), {OUT_W{1'b0}}};
            end
        end else if (cfg_we && !adv) begin
            entries[cfg_addr] <= cfg_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we & adv;
        end
    end

`ifdef PROGRAMMABLE_MEALY_FSM_TRANS_CNT_EN
    logic [15:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= 16'h0000;
        end else if (adv && (next_state != cur_state)) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign trans_cnt = cnt;
`else
    assign trans_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_programmable_mealy_fsm.sv
// Scoreboard bench for programmable_mealy_fsm: driver pushes model expectations, negedge monitor pops and compares.
module tb_programmable_mealy_fsm;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic [1:0] in_x = 2'b00;
    logic [1:0] out_y;
    logic [1:0] cur_state;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_addr = 4'h0;
    logic [3:0] cfg_wdata = 4'h0;
    logic       cfg_err;
    logic [15:0] trans_cnt;

    programmable_mealy_fsm dut (
        .clock(clock), .reset(reset), .run(run), .step(step), .in_x(in_x),
        .out_y(out_y), .cur_state(cur_state), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_err(cfg_err), .trans_cnt(trans_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  y;
        logic [1:0]  s;
        logic        e;
        logic [15:0] c;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: next-state and output tables indexed by state*4+input.
    int m_ns [16];
    int m_out[16];
    int m_st, m_err, m_cnt;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_ns[i]  = i / 4;
            m_out[i] = 0;
        end
        m_st = 0; m_err = 0; m_cnt = 0;
    endfunction

    function automatic void model_edge(input logic r, input logic ru, input logic st,
                                       input logic we, input logic [3:0] a,
                                       input logic [3:0] d, input logic [1:0] x);
        int nxt;
        bit advance;
        if (r) begin
            model_reset();
            return;
        end
        advance = ru || st;
        nxt = m_ns[m_st * 4 + int'(x)];
        m_err = (we && advance) ? 1 : 0;
        if (we && !advance) begin
            m_ns[a]  = int'(d) / 4;
            m_out[a] = int'(d) % 4;
        end
        if (advance) begin
`ifdef PROGRAMMABLE_MEALY_FSM_TRANS_CNT_EN
            if (nxt != m_st) m_cnt = (m_cnt + 1) % 65536;
`endif
            m_st = nxt;
        end
    endfunction

    task automatic cyc(input logic r, input logic ru, input logic st, input logic we,
                       input logic [3:0] a, input logic [3:0] d, input logic [1:0] x);
        exp_t e;
        reset = r; run = ru; step = st; cfg_we = we; cfg_addr = a; cfg_wdata = d; in_x = x;
        if (!r) begin
            e.y = 2'(m_out[m_st * 4 + int'(x)]);
            e.s = 2'(m_st);
            e.e = (m_err != 0);
            e.c = 16'(m_cnt);
            q.push_back(e);
        end
        @(posedge clock);
        model_edge(r, ru, st, we, a, d, x);
        #1;
    endtask

    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks += 4;
            if (out_y !== e.y) begin
                errors++;
                $display("FAIL out_y at %0t: got %0h expected %0h", $time, out_y, e.y);
            end
            if (cur_state !== e.s) begin
                errors++;
                $display("FAIL cur_state at %0t: got %0h expected %0h", $time, cur_state, e.s);
            end
            if (cfg_err !== e.e) begin
                errors++;
                $display("FAIL cfg_err at %0t: got %0b expected %0b", $time, cfg_err, e.e);
            end
            if (trans_cnt !== e.c) begin
                errors++;
                $display("FAIL trans_cnt at %0t: got %0h expected %0h", $time, trans_cnt, e.c);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    int tbl_ns [16] = '{0,1,2,3, 0,0,2,2, 0,1,2,1, 1,1,1,1};
    int tbl_out[16] = '{0,1,2,2, 0,1,2,2, 0,1,2,1, 1,1,1,1};
    logic [1:0] seq4 [5] = '{2'b11, 2'b00, 2'b01, 2'b10, 2'b11};

    initial begin
        model_reset();
        @(posedge clock); #1;
        cyc(1, 0, 0, 0, 4'h0, 4'h0, 2'b00);

        // Reset defaults, sweep inputs with run low.
        for (int x = 0; x < 4; x++) cyc(0, 0, 0, 0, 4'h0, 4'h0, 2'(x));

        // Single write then step.
        cyc(0, 0, 0, 1, 4'b0001, 4'b0101, 2'b01);
        cyc(0, 0, 0, 0, 4'h0, 4'h0, 2'b01);
        cyc(0, 0, 1, 0, 4'h0, 4'h0, 2'b01);
        cyc(0, 0, 0, 0, 4'h0, 4'h0, 2'b00);

        // Back to state 0, then write colliding with run.
        cyc(1, 0, 0, 0, 4'h0, 4'h0, 2'b00);
        cyc(0, 1, 0, 1, 4'b0000, 4'b1111, 2'b00);
        cyc(0, 0, 0, 0, 4'h0, 4'h0, 2'b00);
        cyc(0, 0, 0, 0, 4'h0, 4'h0, 2'b00);
        cyc(0, 1, 1, 1, 4'b0000, 4'b1111, 2'b00);
        cyc(0, 0, 0, 0, 4'h0, 4'h0, 2'b00);

        // Program the full table and run the sequence.
        for (int i = 0; i < 16; i++)
            cyc(0, 0, 0, 1, 4'(i), 4'(tbl_ns[i] * 4 + tbl_out[i]), 2'b00);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 4'h0, 4'h0, seq4[i]);

        // Reach state 2 and hold on its self-loop.
        cyc(0, 0, 1, 0, 4'h0, 4'h0, 2'b10);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 4'h0, 4'h0, 2'b10);

        // Overwrite the currently addressed entry while idle.
        cyc(0, 0, 0, 1, 4'b1010, 4'b1011, 2'b10);
        cyc(0, 0, 0, 0, 4'h0, 4'h0, 2'b10);
        cyc(0, 0, 0, 1, 4'b1010, 4'b1010, 2'b10);

        // Move to state 3, reset while running, check table restored.
        cyc(0, 1, 0, 0, 4'h0, 4'h0, 2'b00);
        cyc(0, 1, 0, 0, 4'h0, 4'h0, 2'b11);
        cyc(0, 1, 0, 0, 4'h0, 4'h0, 2'b00);
        cyc(1, 1, 0, 1, 4'h0, 4'hF, 2'b00);
        for (int x = 0; x < 4; x++) cyc(0, 0, 0, 0, 4'h0, 4'h0, 2'(x));

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
                4'($urandom), 4'($urandom), 2'($urandom));
        end
        cyc(0, 0, 0, 0, 4'h0, 4'h0, 2'b00);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clock);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
